sevenseg_rx: RTL and testbench

//  Receive side of the multiplexed seven-segment display bus: samples segments a..g, dp
//  and the one-hot digit select, and waits until the bus holds steady.

---
 rtl/sevenseg_rx_if.sv | 26 ++
 rtl/sevenseg_rx.sv | 131 +++++++++++++
 tb/tb_sevenseg_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_rx_if.sv
// Seven-segment display bus plus the decoded-slot results of the receiver.
// The receiver uses the slave modport; the driver side uses master.
interface sevenseg_rx_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    a, b, c, d, e, f, g, dp;
  logic [NUM_DIGITS-1:0]   digit;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic [NUM_DIGITS-1:0]   valid_out;
  logic                    upd;
  logic [IDX_W-1:0]        upd_idx;
  logic                    err;

  modport master (
    output a, b, c, d, e, f, g, dp, digit,
    input  hex_out, dp_out, valid_out, upd, upd_idx, err
  );

  modport slave (
    input  a, b, c, d, e, f, g, dp, digit,
    output hex_out, dp_out, valid_out, upd, upd_idx, err
  );
endinterface

// File: rtl/sevenseg_rx.sv
// Seven-segment bus receiver: waits for the bus to settle, decodes the segment
// pattern back to hex and stores it in the slot picked by the one-hot digit select.
module sevenseg_rx #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  sevenseg_rx_if.slave  bus
);
  localparam int SW    = NUM_DIGITS + 8;
  localparam int CW    = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [SW-1:0]                 s_d, s_q;
  logic [CW-1:0]                 cnt_d, cnt_q;
  logic [1:0]                    state_d, state_q;
  logic                          first_d, first_q;
  logic [NUM_DIGITS-1:0][3:0]    hex_d, hex_q;
  logic [NUM_DIGITS-1:0]         dpo_d, dpo_q;
  logic [NUM_DIGITS-1:0]         vld_d, vld_q;
  logic                          upd_d, upd_q;
  logic [IDX_W-1:0]              idx_d, idx_q;
  logic                          err_d, err_q;
  logic                          chg;
  logic [NUM_DIGITS-1:0]         sel;
  logic [4:0]                    dec;

  // {legal, value}; anything outside the 16 glyphs decodes as illegal
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h10;  7'h06: return 5'h11;
      7'h5B: return 5'h12;  7'h4F: return 5'h13;
      7'h66: return 5'h14;  7'h6D: return 5'h15;
      7'h7D: return 5'h16;  7'h07: return 5'h17;
      7'h7F: return 5'h18;  7'h6F: return 5'h19;
      7'h77: return 5'h1A;  7'h7C: return 5'h1B;
      7'h39: return 5'h1C;  7'h5E: return 5'h1D;
      7'h79: return 5'h1E;  7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    s_d     = {bus.digit, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a, bus.dp};
    // the first sample after reset is treated as a change so a blank bus still settles
    chg     = first_q || (s_d != s_q);
    first_d = 1'b0;

    cnt_d = cnt_q;
    if (chg)                              cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES)) cnt_d = cnt_q + 1'b1;

    state_d = state_q;
    if (chg) state_d = SETTLE;
    else begin
      case (state_q)
        SETTLE:  if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = COMMIT;
        COMMIT:  state_d = HOLD;
        default: state_d = state_q;
      endcase
    end

    // commit acts on the settled sample still in s_q, even if the bus moves this edge
    sel   = s_q[SW-1:8];
    dec   = seg_decode(s_q[7:1]);
    hex_d = hex_q;
    dpo_d = dpo_q;
    vld_d = vld_q;
    idx_d = idx_q;
    upd_d = 1'b0;
    err_d = 1'b0;
    if (state_q == COMMIT && sel != '0) begin
      if (!$onehot(sel)) err_d = 1'b1;
      else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            if (dec[4]) begin
              hex_d[i] = dec[3:0];
              dpo_d[i] = s_q[0];
              vld_d[i] = 1'b1;
              idx_d    = IDX_W'(i);
              upd_d    = 1'b1;
            end else begin
              vld_d[i] = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      first_q <= 1'b1;
      hex_q   <= '0;
      dpo_q   <= '0;
      vld_q   <= '0;
      upd_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      first_q <= first_d;
      hex_q   <= hex_d;
      dpo_q   <= dpo_d;
      vld_q   <= vld_d;
      upd_q   <= upd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.dp_out    = dpo_q;
  assign bus.valid_out = vld_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = idx_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sevenseg_rx.sv
// Randomized bench for sevenseg_rx: a run-length model of the bus predicts every
// commit and the full slot state, compared one step after each rising edge.
module tb_sevenseg_rx;
  localparam int ND = 4;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_rx_if #(.NUM_DIGITS(ND)) bus ();
  sevenseg_rx #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [ND-1:0] cur_digit = '0;
  logic [6:0]    cur_pat   = '0;
  logic          cur_dp    = 1'b0;

  assign bus.digit = cur_digit;
  assign {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = cur_pat;
  assign bus.dp    = cur_dp;

  logic [6:0] legal [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference state
  logic [3:0]    m_hex [ND];
  logic [ND-1:0] m_dp, m_vld;
  logic          m_upd, m_err;
  int            m_idx;
  int            run_len;
  logic [ND+7:0] prev_smp;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_hex[i] = '0;
    m_dp = '0; m_vld = '0; m_upd = 0; m_err = 0; m_idx = 0;
    run_len = 0; prev_smp = '0;
  endtask

  task automatic model_commit(input logic [ND+7:0] smp);
    logic [ND-1:0] dg;
    int found, slot;
    dg = smp[ND+7:8];
    if (dg == '0) return;
    if ($countones(dg) != 1) begin m_err = 1; return; end
    slot = 0;
    for (int i = 0; i < ND; i++) if (dg[i]) slot = i;
    found = -1;
    for (int v = 0; v < 16; v++) if (legal[v] == smp[7:1]) found = v;
    if (found < 0) begin
      m_err = 1; m_vld[slot] = 0;
    end else begin
      m_hex[slot] = 4'(found); m_dp[slot] = smp[0]; m_vld[slot] = 1;
      m_upd = 1; m_idx = slot;
    end
  endtask

  // a value that has been sampled ST+1 times in a row commits on the following edge
  task automatic model_edge();
    logic [ND+7:0] smp;
    if (rst) begin model_reset(); return; end
    m_upd = 0; m_err = 0;
    if (run_len == ST + 1) model_commit(prev_smp);
    smp = {cur_digit, cur_pat, cur_dp};
    if (run_len == 0 || smp != prev_smp) run_len = 1;
    else if (run_len < ST + 2)           run_len++;
    prev_smp = smp;
  endtask

  task automatic compare();
    logic [4*ND-1:0] eh;
    for (int i = 0; i < ND; i++) eh[4*i +: 4] = m_hex[i];
    chk("hex_out",   64'(bus.hex_out),   64'(eh));
    chk("dp_out",    64'(bus.dp_out),    64'(m_dp));
    chk("valid_out", 64'(bus.valid_out), 64'(m_vld));
    chk("upd",       64'(bus.upd),       64'(m_upd));
    chk("err",       64'(bus.err),       64'(m_err));
    if (m_upd) chk("upd_idx", 64'(bus.upd_idx), 64'(m_idx));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic hold(input logic [ND-1:0] dg, input logic [6:0] pat, input logic dpv, input int n);
    cur_digit = dg; cur_pat = pat; cur_dp = dpv;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  initial begin
    logic [ND-1:0] dg;
    logic [6:0]    pt;
    int            r;
    model_reset();
    do_reset(2);
    // steady glyph, glitch then settle, illegal pattern, bad select, blank
    hold(4'b0001, 7'h3F, 0, 20);
    hold(4'b0010, 7'h06, 0, 2);
    hold(4'b0010, 7'h5B, 0, 10);
    hold(4'b0100, 7'h77, 0, 8);
    hold(4'b0100, 7'h01, 0, 8);
    hold(4'b0011, 7'h3F, 0, 8);
    hold(4'b0000, 7'h3F, 0, 10);
    // scan all glyphs across the slots
    for (int v = 0; v < 16; v++) begin
      dg = 4'b0001 << (v % ND);
      hold(dg, legal[v], v[0], 8);
    end
    // reset mid-settle, then the same pattern after release
    hold(4'b1000, 7'h7F, 0, 3);
    do_reset(1);
    hold(4'b1000, 7'h7F, 0, 10);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) do_reset(int'($urandom_range(1, 3)));
      r = int'($urandom_range(0, 99));
      if (r < 60)      dg = 4'b0001 << $urandom_range(0, ND - 1);
      else if (r < 75) dg = '0;
      else             dg = 4'($urandom);
      if ($urandom_range(0, 99) < 80) pt = legal[$urandom_range(0, 15)];
      else                            pt = 7'($urandom);
      hold(dg, pt, 1'($urandom), int'($urandom_range(1, 8)));
    end
    hold(4'b0000, 7'h00, 0, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
